// File: rtl/iram_loader_if.sv
// Bus between the boot/host link and the IRAM loader: load control, word stream,
// IRAM write port and completion status.
interface iram_loader_if #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned ADDR_W = 9
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              busy;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] checksum;

    modport master (
        output start, abort, base_addr, length, in_valid, in_data,
        input  in_ready, mem_write, mem_addr, mem_din, busy, done, error, checksum
    );

    modport slave (
        input  start, abort, base_addr, length, in_valid, in_data,
        output in_ready, mem_write, mem_addr, mem_din, busy, done, error, checksum
    );
endinterface

// File: rtl/iram_loader.sv
// Streams instruction words into consecutive IRAM locations from a base address,
// reporting completion with a pulse and a running modular checksum.
module iram_loader #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned ADDR_W = 9
) (
    input logic         clk,
    input logic         rst,
    iram_loader_if.slave bus
);
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  k;
    logic              wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              done_p;
    logic              err;
    logic [DATA_W-1:0] sum;
    logic              ready;
    logic              hs;

    // in_ready depends only on state and abort so the source may wait on it
    assign ready = (state == LOAD) && !bus.abort;
    assign hs    = bus.in_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            len     <= '0;
            k       <= '0;
            wr      <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done_p  <= 1'b0;
            err     <= 1'b0;
            sum     <= '0;
        end else begin
            wr     <= 1'b0;
            done_p <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        base <= bus.base_addr;
                        len  <= bus.length;
                        k    <= '0;
                        sum  <= '0;
                        if (bus.length == '0 || bus.length > LEN_W'(DEPTH)) begin
                            err    <= 1'b1;
                            done_p <= 1'b1;
                        end else begin
                            err   <= 1'b0;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (hs) begin
                        // address arithmetic is ADDR_W wide, so it wraps at DEPTH
                        wr      <= 1'b1;
                        wr_addr <= base + k[ADDR_W-1:0];
                        wr_data <= bus.in_data;
                        sum     <= sum + bus.in_data;
                        k       <= k + LEN_W'(1);
                        if (k == len - LEN_W'(1)) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    if (!bus.abort) begin
                        done_p <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_write = wr;
    assign bus.mem_addr  = wr_addr;
    assign bus.mem_din   = wr_data;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_p;
    assign bus.error     = err;
    assign bus.checksum  = sum;
endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: reset, back-to-back and stalled loads, address
// wrap, illegal lengths, abort and reset mid-load, start while busy.
module tb_iram_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    logic [8:0] wa[$];
    logic [8:0] wd[$];

    iram_loader_if #(.DATA_W(9), .ADDR_W(9)) bus ();

    iram_loader #(.DATA_W(9), .ADDR_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // IRAM-side observer: log every write strobe and every done pulse
    always @(negedge clk) begin
        if (bus.mem_write) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_din);
        end
        if (bus.done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_load(input logic [8:0] b, input logic [9:0] l);
        bus.base_addr = b;
        bus.length    = l;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".in_ready"},  32'(bus.in_ready), 0);
        check({tag, ".mem_write"}, 32'(bus.mem_write), 0);
        check({tag, ".mem_addr"},  32'(bus.mem_addr), 0);
        check({tag, ".mem_din"},   32'(bus.mem_din), 0);
        check({tag, ".busy"},      32'(bus.busy), 0);
        check({tag, ".done"},      32'(bus.done), 0);
        check({tag, ".error"},     32'(bus.error), 0);
        check({tag, ".checksum"},  32'(bus.checksum), 0);
    endtask

    initial begin
        logic [8:0] bw[4]   = '{9'h001, 9'h0FF, 9'h1E1, 9'h100};
        logic       vpat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [8:0] sw[3]   = '{9'h011, 9'h022, 9'h033};
        logic [8:0] wrap_a[4] = '{9'd510, 9'd511, 9'd0, 9'd1};
        int lw, ld, j;

        bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0; bus.length = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;

        // reset, with start and abort asserted to show rst wins
        bus.start = 1'b1; bus.abort = 1'b1; bus.length = 10'd4;
        step(); step();
        check_all_zero("reset");
        bus.start = 1'b0; bus.abort = 1'b0;
        rst = 1'b0;
        step();

        // basic back-to-back load
        lw = wa.size(); ld = done_cnt;
        begin_load(9'd0, 10'd4);
        check("basic.busy_after_start", 32'(bus.busy), 1);
        check("basic.ready_after_start", 32'(bus.in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = bw[i];
            step();
            check("basic.mem_write", 32'(bus.mem_write), 1);
            check("basic.mem_addr", 32'(bus.mem_addr), 32'(i));
            check("basic.mem_din", 32'(bus.mem_din), 32'(bw[i]));
        end
        bus.in_valid = 1'b0;
        check("basic.finish_ready", 32'(bus.in_ready), 0);
        check("basic.finish_busy", 32'(bus.busy), 1);
        check("basic.finish_done", 32'(bus.done), 0);
        step();
        check("basic.done", 32'(bus.done), 1);
        check("basic.busy_end", 32'(bus.busy), 0);
        check("basic.checksum", 32'(bus.checksum), 32'h1E1);
        check("basic.error", 32'(bus.error), 0);
        step();
        check("basic.done_one_cycle", 32'(bus.done), 0);
        check("basic.checksum_held", 32'(bus.checksum), 32'h1E1);
        check("basic.write_count", 32'(wa.size() - lw), 4);
        check("basic.done_count", 32'(done_cnt - ld), 1);

        // stalled source
        lw = wa.size(); ld = done_cnt; j = 0;
        begin_load(9'd100, 10'd3);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = vpat[i]; bus.in_data = sw[j];
            step();
            if (vpat[i]) begin
                check("stall.mem_write", 32'(bus.mem_write), 1);
                check("stall.mem_addr", 32'(bus.mem_addr), 32'(100 + j));
                j++;
            end else begin
                check("stall.gap_no_write", 32'(bus.mem_write), 0);
            end
        end
        bus.in_valid = 1'b0;
        step();
        check("stall.done", 32'(bus.done), 1);
        check("stall.checksum", 32'(bus.checksum), 32'h066);
        step();
        check("stall.write_count", 32'(wa.size() - lw), 3);
        check("stall.done_count", 32'(done_cnt - ld), 1);

        // address wrap past the top of IRAM
        lw = wa.size();
        begin_load(9'd510, 10'd4);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 9'(i + 1);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check("wrap.done", 32'(bus.done), 1);
        check("wrap.error", 32'(bus.error), 0);
        check("wrap.checksum", 32'(bus.checksum), 32'h00A);
        check("wrap.write_count", 32'(wa.size() - lw), 4);
        for (int i = 0; i < 4; i++) begin
            if (lw + i < wa.size())
                check("wrap.mem_addr", 32'(wa[lw + i]), 32'(wrap_a[i]));
        end
        step();

        // illegal lengths
        lw = wa.size();
        begin_load(9'd3, 10'd0);
        check("illegal0.done", 32'(bus.done), 1);
        check("illegal0.error", 32'(bus.error), 1);
        check("illegal0.busy", 32'(bus.busy), 0);
        step();
        check("illegal0.done_one_cycle", 32'(bus.done), 0);
        check("illegal0.error_held", 32'(bus.error), 1);
        begin_load(9'd3, 10'd513);
        check("illegal513.done", 32'(bus.done), 1);
        check("illegal513.error", 32'(bus.error), 1);
        check("illegal513.busy", 32'(bus.busy), 0);
        check("illegal513.ready", 32'(bus.in_ready), 0);
        step();
        check("illegal.no_writes", 32'(wa.size() - lw), 0);
        begin_load(9'd5, 10'd1);
        check("legal_after.error_cleared", 32'(bus.error), 0);
        check("legal_after.busy", 32'(bus.busy), 1);
        bus.in_valid = 1'b1; bus.in_data = 9'h007;
        step();
        bus.in_valid = 1'b0;
        check("legal_after.mem_addr", 32'(bus.mem_addr), 5);
        step();
        check("legal_after.done", 32'(bus.done), 1);
        check("legal_after.checksum", 32'(bus.checksum), 32'h007);
        step();

        // abort after three handshakes, with a start pulse while busy
        lw = wa.size(); ld = done_cnt;
        begin_load(9'd20, 10'd8);
        bus.in_valid = 1'b1; bus.in_data = 9'h010;
        step();
        bus.start = 1'b1; bus.base_addr = 9'd300; bus.length = 10'd2;
        bus.in_data = 9'h011;
        step();
        bus.start = 1'b0;
        check("busy_start.mem_addr", 32'(bus.mem_addr), 21);
        check("busy_start.busy", 32'(bus.busy), 1);
        bus.in_data = 9'h012;
        step();
        check("busy_start.mem_addr2", 32'(bus.mem_addr), 22);
        bus.abort = 1'b1; bus.in_data = 9'h1FF;
        #1;
        check("abort.ready_low", 32'(bus.in_ready), 0);
        check("abort.prev_write_visible", 32'(bus.mem_write), 1);
        step();
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        check("abort.busy", 32'(bus.busy), 0);
        check("abort.no_write", 32'(bus.mem_write), 0);
        check("abort.no_done", 32'(bus.done), 0);
        step(); step();
        check("abort.write_count", 32'(wa.size() - lw), 3);
        check("abort.done_count", 32'(done_cnt - ld), 0);
        check("abort.checksum", 32'(bus.checksum), 32'h033);

        // reset mid-load
        ld = done_cnt;
        begin_load(9'd0, 10'd8);
        bus.in_valid = 1'b1; bus.in_data = 9'h0AA;
        step(); step();
        rst = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check_all_zero("midreset");
        rst = 1'b0;
        step(); step();
        check("midreset.done_count", 32'(done_cnt - ld), 0);
        check("midreset.busy", 32'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/iram_loader.md
# iram_loader

Sequential write-side master for the 9-bit instruction RAM. Accepts a stream of instruction words over a valid/ready handshake and writes them into consecutive IRAM locations from a programmable base address, raising a done pulse with a running checksum when the programmed length has been written. It sits between the boot/host link and the IRAM write port, filling memory before the processor fetch path reads it.

## Interface
- DATA_W, 9, instruction word width (matches IRAM din/dout)
- ADDR_W, 9, IRAM address width
- DEPTH, 512, IRAM word count (2**ADDR_W)
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  single-cycle request to begin a load; honoured only in IDLE
- abort  input  1  cancel an in-progress load
- base_addr  input  ADDR_W  first IRAM address; sampled on accepted start
- length  input  ADDR_W+1  words to write; sampled on accepted start
- in_valid  input  1  in_data holds a word
- in_data  input  DATA_W  instruction word
- in_ready  output  1  loader accepts a word this cycle
- mem_write  output  1  IRAM write strobe
- mem_addr  output  ADDR_W  IRAM write address
- mem_din  output  DATA_W  IRAM write data
- busy  output  1  state is not IDLE
- done  output  1  one-cycle completion pulse
- error  output  1  last start had illegal length; held until next accepted start
- checksum  output  DATA_W  sum of accepted words mod 2**DATA_W; held until next accepted start

## Operation
- States: IDLE, LOAD, FINISH.
- IDLE + start: latch base_addr, length; clear word counter k, checksum, error.
  - length == 0 or length > DEPTH: stay IDLE, next cycle done=1 and error=1; no writes.
  - otherwise: go to LOAD.
- start while busy: ignored, no side effects.
- LOAD: in_ready = 1 unless abort is high. Handshake = in_valid && in_ready.
  - On handshake: register mem_write=1, mem_addr=(base+k) mod 2**ADDR_W, mem_din=in_data; checksum += in_data (truncated); k += 1.
  - Handshake with k == length-1: go to FINISH.
  - No handshake: mem_write=0 next cycle; state held indefinitely (no timeout).
- FINISH: in_ready=0; lasts one cycle; then IDLE with done=1.
- abort in LOAD or FINISH: IDLE next cycle, no done, error unchanged; the word offered in the abort cycle is not accepted; a write registered from the previous cycle still appears.
- abort in IDLE: no effect.
- Address wraps past DEPTH-1 to 0 (e.g. base 510, length 4 -> 510, 511, 0, 1).

## Timing
- Reset (rst=1 at a clk edge): state IDLE; in_ready, mem_write, mem_addr, mem_din, busy, done, error, checksum all 0. rst overrides start and abort in the same cycle. Reset mid-load discards the load, no done.
- mem_write/mem_addr/mem_din are registered: handshake at edge N -> write visible during cycle N+1, sampled by IRAM at edge N+1.
- Throughput: one word per cycle while in_valid held high.
- Start accepted at edge S -> busy=1 and in_ready=1 from cycle S+1.
- Final handshake at edge N -> cycle N+1: FINISH, final mem_write=1, in_ready=0 -> cycle N+2: IDLE, done=1, busy=0, checksum final.
- Illegal length: start at edge S -> done=1, error=1, busy=0 in cycle S+1.
- done is high exactly one cycle; next start may be accepted in the done cycle.
- in_ready is combinational from state and abort only (not from in_valid).

## Test plan
- Reset then idle: assert rst two cycles -> all outputs 0; start with no rst -> busy=1 next cycle.
- Basic load: base 0, length 4, words 0x001,0x0FF,0x1E1,0x100 back-to-back -> writes at addr 0..3 on consecutive cycles, done two cycles after last handshake, checksum 0x1E1.
- Stalls: base 100, length 3, in_valid toggled 1,0,0,1,0,1 -> writes only one cycle after each handshake to 100,101,102; mem_write=0 in gaps; one done.
- Wrap: base 510, length 4 -> mem_addr 510,511,0,1; error=0.
- Illegal length: length 0, then length 513 -> each gives done=1, error=1 next cycle, no mem_write; subsequent legal start clears error.
- Abort/reset mid-load: length 8, abort after 3 handshakes -> exactly 3 writes, no done, busy=0 next cycle; repeat with rst -> all outputs 0 next cycle; start during busy ignored (base/length unchanged).
